// File: rtl/dec_dispatch_ctrl.sv
// rtl/dec_dispatch_ctrl.sv - two-wide in-order dispatch queue between fetch and the dual-slot decoder
module dec_dispatch_ctrl #(
   parameter int PC    = 16,
   parameter int INS   = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [INS-1:0]             f_ins1,
   input  logic [PC-1:0]              f_pc1,
   input  logic                       f_v1,
   input  logic [INS-1:0]             f_ins2,
   input  logic [PC-1:0]              f_pc2,
   input  logic                       f_v2,
   output logic                       f_ready,
   input  logic [1:0]                 rob_slots,
   input  logic                       stall,
   input  logic                       flush,
   output logic [INS-1:0]             instruction1,
   output logic                       ins1_valid,
   output logic [PC-1:0]              PC_in1,
   output logic [INS-1:0]             instruction2,
   output logic                       ins2_valid,
   output logic [PC-1:0]              PC_in2,
   output logic [$clog2(DEPTH):0]     q_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [INS-1:0] ins_mem_q [DEPTH];
   logic [PC-1:0]  pc_mem_q  [DEPTH];

   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]  count_q, count_d;

   logic [INS-1:0] ins1_q, ins2_q;
   logic [PC-1:0]  pc1_q, pc2_q;
   logic           v1_q, v2_q;

   logic           push_en;
   logic [1:0]     n_push;
   logic [1:0]     credit;
   logic [1:0]     n_pop;

   // Room for a full pair is judged on the registered count only, so a pop this cycle never frees space early
   assign f_ready = (count_q <= CW'(DEPTH - 2));

   // Push/pop amounts and next pointer/count values; flush suppresses both sides
   always_comb begin
      push_en  = f_ready && !flush && !rst;
      n_push   = push_en ? (2'(f_v1) + 2'(f_v2)) : 2'd0;
      credit   = (rob_slots == 2'd3) ? 2'd2 : rob_slots;
      n_pop    = 2'd0;
      if (!stall && !flush) begin
         if (count_q < CW'(credit)) begin
            n_pop = count_q[1:0];
         end else begin
            n_pop = credit;
         end
      end
      count_d  = count_q + CW'(n_push) - CW'(n_pop);
      rd_ptr_d = rd_ptr_q + AW'(n_pop);
      wr_ptr_d = wr_ptr_q + AW'(n_push);
   end

   // Entry storage; a lone lane-2 fetch is compacted into the wr_ptr slot
   always_ff @(posedge clk) begin
      if (push_en && f_v1) begin
         ins_mem_q[wr_ptr_q] <= f_ins1;
         pc_mem_q[wr_ptr_q]  <= f_pc1;
      end
      if (push_en && f_v2) begin
         ins_mem_q[wr_ptr_q + AW'(f_v1)] <= f_ins2;
         pc_mem_q[wr_ptr_q + AW'(f_v1)]  <= f_pc2;
      end
   end

   // Queue bookkeeping and registered dispatch slots; unused slot data holds its last value
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         v1_q     <= 1'b0;
         v2_q     <= 1'b0;
         ins1_q   <= '0;
         ins2_q   <= '0;
         pc1_q    <= '0;
         pc2_q    <= '0;
      end else if (flush) begin
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         v1_q     <= 1'b0;
         v2_q     <= 1'b0;
      end else begin
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         v1_q     <= (n_pop != 2'd0);
         v2_q     <= (n_pop == 2'd2);
         if (n_pop != 2'd0) begin
            ins1_q <= ins_mem_q[rd_ptr_q];
            pc1_q  <= pc_mem_q[rd_ptr_q];
         end
         if (n_pop == 2'd2) begin
            ins2_q <= ins_mem_q[rd_ptr_q + AW'(1)];
            pc2_q  <= pc_mem_q[rd_ptr_q + AW'(1)];
         end
      end
   end

   assign instruction1 = ins1_q;
   assign instruction2 = ins2_q;
   assign PC_in1       = pc1_q;
   assign PC_in2       = pc2_q;
   assign ins1_valid   = v1_q;
   assign ins2_valid   = v2_q;
   assign q_count      = count_q;

endmodule
